// File: rtl/fpu_pkg.sv
// Shared floating-point constants and the default latency of the int-to-float unit.
package fpu_pkg;
    localparam int          FPU_CVT_LAT = 2;
    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
endpackage

// File: rtl/cvt_result_fifo.sv
// Result buffer for converted values: circular FIFO with an occupancy count.
module cvt_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    // Wrap explicitly so non-power-of-two depths still index correctly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (push && !do_pop)
                count <= count + 1'b1;
            else if (!push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // A push into a full buffer is only legal when the head leaves on the same edge.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == ($clog2(DEPTH)+1)'(DEPTH)) && !do_pop));
endmodule

// File: rtl/itof_issue.sv
// Issues integers to a fixed-latency int-to-float unit, tracks them in flight,
// and buffers results with credit-based flow control so the buffer never overflows.
module itof_issue
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CVT_LAT = FPU_CVT_LAT,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      cv_x,
    input  logic [31:0]      cv_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CW    = $clog2(DEPTH + CVT_LAT + 1) + 1;

    logic [CVT_LAT-1:0]   vld_sr;
    logic [TAG_W-1:0]     tag_sr [CVT_LAT];
    logic                 issue;
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        pending;
    logic [CNT_W-1:0]     fifo_count;
    logic [32+TAG_W-1:0]  head;

    // Credit uses only registered state; a pop this cycle frees space next cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < CVT_LAT; i++)
            inflight = inflight + CW'(vld_sr[i]);
        pending  = CW'(fifo_count) + inflight;
        in_ready = !rst && (pending < CW'(DEPTH));
    end

    assign issue = in_valid && in_ready;
    assign cv_x  = issue ? in_data : FP_ZERO;

    // Stage boundary: in-flight valid/tag slots, one per conversion-unit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < CVT_LAT; i++)
                vld_sr[i] <= vld_sr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_sr[0] <= in_tag;
        for (int i = 1; i < CVT_LAT; i++)
            tag_sr[i] <= tag_sr[i-1];
    end

    // Stage boundary: capture the unit's result into the buffer.
    cvt_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32 + TAG_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_sr[CVT_LAT-1]),
        .push_data ({cv_y, tag_sr[CVT_LAT-1]}),
        .pop       (out_valid && out_ready),
        .head_data (head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = head[32+TAG_W-1:TAG_W];
    assign out_tag   = head[TAG_W-1:0];
endmodule

// File: tb/tb_itof_issue.sv
// Randomised and directed bench for itof_issue paired with a behavioural int-to-float unit.
module tb_itof_issue;
    import fpu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CVT_LAT = 2;
    localparam int TAG_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      cv_x;
    logic [31:0]      cv_y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    itof_issue #(.DEPTH(DEPTH), .CVT_LAT(CVT_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .cv_x(cv_x), .cv_y(cv_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Truncating (round toward zero) int32 to IEEE-754 single.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic [31:0] mag;
        logic [31:0] norm;
        int          p;
        if (x == 32'h0)
            return 32'h0;
        mag = x[31] ? (~x + 32'd1) : x;
        p = 0;
        for (int i = 0; i < 32; i++)
            if (mag[i]) p = i;
        norm = mag << (31 - p);
        return {x[31], 8'(127 + p), norm[30:8]};
    endfunction

    // Conversion unit: fixed CVT_LAT pipeline, no reset, samples cv_x every edge.
    logic [31:0] cvt_p [CVT_LAT];
    always_ff @(posedge clk) begin
        cvt_p[0] <= i2f(cv_x);
        for (int i = 1; i < CVT_LAT; i++)
            cvt_p[i] <= cvt_p[i-1];
    end
    assign cv_y = cvt_p[CVT_LAT-1];

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               rdy;
    } ent_t;

    ent_t        q[$];
    logic [31:0] got_q[$];
    int          cyc    = 0;
    int          acc_n  = 0;
    int          n_chk  = 0;
    int          n_err  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
    task automatic step(input logic v, input logic [31:0] d, input logic [TAG_W-1:0] t,
                        input logic ordy, input logic r);
        logic exp_rdy, acc, exp_ov, pop;
        in_valid  = v;
        in_data   = d;
        in_tag    = t;
        out_ready = ordy;
        rst       = r;
        @(negedge clk);
        exp_rdy = !r && (q.size() < DEPTH);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = v && exp_rdy;
        check("cv_x", 64'(cv_x), acc ? 64'(d) : 64'(0));
        exp_ov = (q.size() > 0) && (q[0].rdy <= cyc);
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            check("out_data", 64'(out_data), 64'(i2f(q[0].data)));
            check("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
        pop = exp_ov && ordy;
        if (pop && out_valid)
            got_q.push_back(out_data);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
        end else begin
            if (pop)
                void'(q.pop_front());
            if (acc) begin
                q.push_back('{data: d, tag: t, rdy: cyc + CVT_LAT + 1});
                acc_n++;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++)
            step(1'b0, 32'h0, '0, ordy, 1'b0);
    endtask

    initial begin
        logic [31:0] exp4 [4];
        logic [31:0] src4 [4];
        int          base;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single conversion of 1: result one edge after the unit latency.
        got_q.delete();
        step(1'b1, 32'h1, 4'd1, 1'b1, 1'b0);
        idle(5, 1'b1);
        check("one_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0)
            check("one_value", 64'(got_q[0]), 64'(FP_ONE));

        // Back-to-back edge values, constant expectations.
        src4 = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        exp4 = '{32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000, 32'h4EFF_FFFF};
        got_q.delete();
        for (int i = 0; i < 4; i++)
            step(1'b1, src4[i], TAG_W'(i + 2), 1'b1, 1'b0);
        idle(6, 1'b1);
        check("b2b_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("b2b_value", 64'(got_q[i]), 64'(exp4[i]));

        // Back-pressure: only DEPTH requests may be outstanding.
        base = acc_n;
        got_q.delete();
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'd100 + 32'(i), TAG_W'(i), 1'b0, 1'b0);
        check("bp_accepted", 64'(acc_n - base), 64'd4);
        idle(8, 1'b1);
        check("bp_drained", 64'(got_q.size()), 64'd4);

        // Full buffer, then continuous issue while popping with an irregular consumer.
        for (int i = 0; i < 7; i++)
            step(1'b1, 32'(-i * 1000), TAG_W'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'(i * 77777), TAG_W'(i), (i % 3) != 2, 1'b0);
        idle(10, 1'b1);

        // Reset with one buffered and two in flight; nothing stale may appear afterwards.
        step(1'b1, 32'd11, 4'd11, 1'b0, 1'b0);
        step(1'b1, 32'd12, 4'd12, 1'b0, 1'b0);
        step(1'b1, 32'd13, 4'd13, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b0, 1'b1);
        got_q.delete();
        idle(5, 1'b1);
        check("rst_no_stale", 64'(got_q.size()), 64'd0);
        step(1'b1, 32'd42, 4'd7, 1'b1, 1'b0);
        idle(5, 1'b1);
        check("rst_new_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0)
            check("rst_new_value", 64'(got_q[0]), 64'h4228_0000);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom, TAG_W'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        idle(10, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
